// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer type, size and burst encodings shared by the master arbiter
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} HTRANS_e;
  typedef enum logic [3:0] {BITS8 = 4'd0, BITS16 = 4'd1, BITS32 = 4'd2} HSIZE_e;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } HBURST_e;
endpackage

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req   in  NREQ  request vector
//   ptr   in  PW    highest-priority index
//   grant out NREQ  one-hot winner (0 when no request)
//   idx   out PW    winner index
//   any   out 1     some request is present
module ahb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [PW:0]   sum;
  logic [PW-1:0] j;
  // Scan from the farthest offset down so the nearest valid request is written last and wins.
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    j = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      j = PW'(sum >= (PW+1)'(NREQ) ? sum - (PW+1)'(NREQ) : sum);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: round-robin sharing of one AHB-Lite master port among NREQ single-beat requesters
//   HCLK/HREASETn             clock, async active-low reset
//   req_valid/ready/write     per-requester command handshake (ready is one-hot)
//   req_size/addr/wdata       per-requester flattened command fields
//   rsp_valid/rsp_rdata       one-hot completion pulse and read data
//   HTRANS..HWDATA            AHB-Lite master outputs
//   HREADY/HRDATA             AHB-Lite slave response
import ahb_pkg::*;
module ahb_master_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               HCLK,
  input  logic               HREASETn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*4-1:0]  req_size,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic [1:0]         HTRANS,
  output logic [2:0]         HBURST,
  output logic [3:0]         HSIZE,
  output logic               HWRITE,
  output logic [AW-1:0]      HADDR,
  output logic [DW-1:0]      HWDATA,
  input  logic               HREADY,
  input  logic [DW-1:0]      HRDATA
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0]   ptr, g_idx, a_owner, d_owner;
  logic [NREQ-1:0] g_hot;
  logic            g_any, adv, d_active, d_write;
  logic [DW-1:0]   a_wdata;
  ahb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid), .ptr(ptr), .grant(g_hot), .idx(g_idx), .any(g_any)
  );
  assign adv = HTRANS == IDLE || HREADY;
  // Gated by reset so nothing is reported as accepted while the bus is held in reset.
  assign req_ready = adv && HREASETn ? g_hot : '0;
  assign HBURST = SINGLE;
  always_ff @(posedge HCLK or negedge HREASETn) begin
    if (!HREASETn) begin
      HTRANS <= IDLE;
      HSIZE <= BITS32;
      HWRITE <= 1'b0;
      HADDR <= '0;
      HWDATA <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      ptr <= '0;
      a_owner <= '0;
      a_wdata <= '0;
      d_owner <= '0;
      d_write <= 1'b0;
      d_active <= 1'b0;
    end else begin
      if (adv) begin
        HTRANS <= g_any ? NONSEQ : IDLE;
        if (g_any) begin
          HADDR <= req_addr[g_idx*AW +: AW];
          HWRITE <= req_write[g_idx];
          HSIZE <= req_size[g_idx*4 +: 4];
          a_wdata <= req_wdata[g_idx*DW +: DW];
          a_owner <= g_idx;
          ptr <= g_idx == PW'(NREQ - 1) ? '0 : g_idx + PW'(1);
        end
      end
      // Write data is captured with the address so the requester may drop valid after acceptance.
      if (HREADY) begin
        d_active <= HTRANS == NONSEQ;
        if (HTRANS == NONSEQ) begin
          d_owner <= a_owner;
          d_write <= HWRITE;
          HWDATA <= a_wdata;
        end
      end
      rsp_valid <= HREADY && d_active ? NREQ'(1) << d_owner : '0;
      if (HREADY && d_active) rsp_rdata <= d_write ? '0 : HRDATA;
    end
  end
endmodule
